// File: rtl/vga_scan_controller.sv
// rtl/vga_scan_controller.sv - VGA raster scan timing with pixel-strobe-qualified counters
// Define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_scan_controller #(
  parameter int H_SYNC_TIME    = 96,
  parameter int H_BACK_PROCH   = 48,
  parameter int H_DISPLAY_TIME = 640,
  parameter int H_FRONT_PROCH  = 16,
  parameter int V_SYNC_TIME    = 2,
  parameter int V_BACK_PROCH   = 33,
  parameter int V_DISPLAY_TIME = 480,
  parameter int V_FRONT_PROCH  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_25Mhz,
  input  logic       run,
  output logic       hsync,
  output logic       vsync,
  output logic       display_enable,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic       busy
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int HT  = H_SYNC_TIME + H_BACK_PROCH + H_DISPLAY_TIME + H_FRONT_PROCH;
  localparam int VT  = V_SYNC_TIME + V_BACK_PROCH + V_DISPLAY_TIME + V_FRONT_PROCH;
  localparam int HCW = $clog2(HT);
  localparam int VCW = $clog2(VT);

  localparam logic [HCW-1:0] H_LAST     = HCW'(HT - 1);
  localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_SYNC_TIME);
  localparam logic [HCW-1:0] H_DISP_BEG = HCW'(H_SYNC_TIME + H_BACK_PROCH);
  localparam logic [HCW-1:0] H_DISP_END = HCW'(H_SYNC_TIME + H_BACK_PROCH + H_DISPLAY_TIME);
  localparam logic [VCW-1:0] V_LAST     = VCW'(VT - 1);
  localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_SYNC_TIME);
  localparam logic [VCW-1:0] V_DISP_BEG = VCW'(V_SYNC_TIME + V_BACK_PROCH);
  localparam logic [VCW-1:0] V_DISP_END = VCW'(V_SYNC_TIME + V_BACK_PROCH + V_DISPLAY_TIME);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t         r_state, w_state_nxt;
  logic [HCW-1:0] r_h_cnt, w_h_nxt;
  logic [VCW-1:0] r_v_cnt, w_v_nxt;
  logic           r_adv, w_adv;
  logic           w_h_wrap, w_v_wrap, w_busy, w_de, w_ls, w_fs;

  logic           r_hsync, r_vsync, r_de, r_ls, r_fs, r_busy;
  logic [9:0]     r_px, r_py;

  assign w_h_wrap = (r_h_cnt == H_LAST);
  assign w_v_wrap = (r_v_cnt == V_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h_cnt;
    w_v_nxt     = r_v_cnt;
    w_adv       = 1'b0;
    if (clk_25Mhz) begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            w_state_nxt = ST_RUN;
            w_h_nxt     = '0;
            w_v_nxt     = '0;
            w_adv       = 1'b1;
          end
        end
        default: begin
          w_adv   = 1'b1;
          w_h_nxt = w_h_wrap ? '0 : r_h_cnt + HCW'(1);
          if (w_h_wrap)
            w_v_nxt = w_v_wrap ? '0 : r_v_cnt + VCW'(1);
          // Without run, scanning continues only until the current frame completes.
          if (run)
            w_state_nxt = ST_RUN;
          else if (w_h_wrap && w_v_wrap)
            w_state_nxt = ST_IDLE;
          else
            w_state_nxt = ST_DRAIN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_h_cnt <= w_h_nxt;
      r_v_cnt <= w_v_nxt;
      r_adv   <= w_adv;
    end
  end

  // Outputs decode the counter one clk after it moved; r_adv marks that fresh value.
  assign w_busy = (r_state != ST_IDLE);
  assign w_de   = w_busy && (r_h_cnt >= H_DISP_BEG) && (r_h_cnt < H_DISP_END)
                         && (r_v_cnt >= V_DISP_BEG) && (r_v_cnt < V_DISP_END);
  assign w_ls   = w_busy && r_adv && (r_h_cnt == '0);
  assign w_fs   = w_ls && (r_v_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_px    <= '0;
      r_py    <= '0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_hsync <= ~(w_busy && (r_h_cnt < H_SYNC_END));
      r_vsync <= ~(w_busy && (r_v_cnt < V_SYNC_END));
      r_de    <= w_de;
      r_px    <= w_de ? 10'(r_h_cnt - H_DISP_BEG) : '0;
      r_py    <= w_de ? 10'(r_v_cnt - V_DISP_BEG) : '0;
      r_ls    <= w_ls;
      r_fs    <= w_fs;
      r_busy  <= w_busy;
    end
  end

  assign hsync          = r_hsync;
  assign vsync          = r_vsync;
  assign display_enable = r_de;
  assign pixel_x        = r_px;
  assign pixel_y        = r_py;
  assign line_start     = r_ls;
  assign frame_start    = r_fs;
  assign busy           = r_busy;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (reset)
      r_frame_count <= '0;
    else if (w_fs)
      r_frame_count <= r_frame_count + 16'd1;
  end

  assign frame_count = r_frame_count;
`endif

endmodule

// File: tb/tb_vga_scan_controller.sv
// tb/tb_vga_scan_controller.sv - vector table, directed sequences and random run against a position model
module tb_vga_scan_controller;
  localparam int HS = 5, HB = 3, HD = 10, HF = 2;
  localparam int VS = 2, VB = 3, VD = 6, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_25Mhz = 1'b0;
  logic       run = 1'b0;
  logic       hsync, vsync, display_enable, line_start, frame_start, busy;
  logic [9:0] pixel_x, pixel_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  vga_scan_controller #(
    .H_SYNC_TIME(HS), .H_BACK_PROCH(HB), .H_DISPLAY_TIME(HD), .H_FRONT_PROCH(HF),
    .V_SYNC_TIME(VS), .V_BACK_PROCH(VB), .V_DISPLAY_TIME(VD), .V_FRONT_PROCH(VF)
  ) dut (
    .clk(clk), .reset(reset), .clk_25Mhz(clk_25Mhz), .run(run),
    .hsync(hsync), .vsync(vsync), .display_enable(display_enable),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start), .busy(busy)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: linear position in the frame plus a scanning flag.
  bit m_busy = 0;
  bit m_adv  = 0;
  int m_pos  = 0;
  int m_fc   = 0;
  bit e_hs, e_vs, e_de, e_ls, e_fs, e_busy;
  int e_px, e_py;

  typedef struct {
    bit rst, stb, rn;
    bit hs, vs, de, ls, fs, bz;
    int px, py;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [31:0] pk(input logic hs, input logic vs, input logic de,
                                     input logic ls, input logic fs, input logic bz,
                                     input logic [9:0] px, input logic [9:0] py);
    return {6'd0, hs, vs, de, ls, fs, bz, px, py};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit rst, input bit stb, input bit rn);
    int h = m_pos % HT;
    int v = m_pos / HT;
    if (rst) begin
      {e_hs, e_vs, e_de, e_ls, e_fs, e_busy} = 6'b110000;
      e_px = 0; e_py = 0;
      m_busy = 0; m_pos = 0; m_adv = 0; m_fc = 0;
    end else begin
      e_busy = m_busy;
      e_hs = !(m_busy && h < HS);
      e_vs = !(m_busy && v < VS);
      e_de = m_busy && h >= HS + HB && h < HS + HB + HD && v >= VS + VB && v < VS + VB + VD;
      e_px = e_de ? h - HS - HB : 0;
      e_py = e_de ? v - VS - VB : 0;
      e_ls = m_busy && m_adv && h == 0;
      e_fs = m_busy && m_adv && m_pos == 0;
      if (e_fs) m_fc = (m_fc + 1) % 65536;
      m_adv = 0;
      if (stb) begin
        if (!m_busy) begin
          if (rn) begin m_busy = 1; m_pos = 0; m_adv = 1; end
        end else begin
          m_adv = 1;
          m_pos = (m_pos + 1) % FT;
          if (!rn && m_pos == 0) m_busy = 0;
        end
      end
    end
  endfunction

  function automatic logic [31:0] act();
    return pk(hsync, vsync, display_enable, line_start, frame_start, busy, pixel_x, pixel_y);
  endfunction

  task automatic step(input bit i_rst, input bit i_stb, input bit i_rn);
    reset = i_rst; clk_25Mhz = i_stb; run = i_rn;
    @(posedge clk);
    model_edge(i_rst, i_stb, i_rn);
    #1;
    chk("model_outputs", int'(act()),
        int'(pk(e_hs, e_vs, e_de, e_ls, e_fs, e_busy, 10'(e_px), 10'(e_py))));
`ifdef VGA_FRAME_COUNT_EN
    chk("frame_count", int'(frame_count), m_fc);
`endif
  endtask

  initial begin
    int cnt, aux, hsl, lsc, fsc, vsl, dec, fpx, fpy, lpx, lpy;
    bit first, rr;

    tbl[0] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7] = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].stb, tbl[i].rn);
      chk($sformatf("table[%0d]", i), int'(act()),
          int'(pk(tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ls, tbl[i].fs, tbl[i].bz,
                  10'(tbl[i].px), 10'(tbl[i].py))));
    end

    // Strobe every 4th clk: start pulse, hsync width and line period.
    step(1, 0, 0); step(0, 1, 1); step(0, 0, 1);
    chk("p4_start_frame_start", int'(frame_start), 1);
    chk("p4_start_line_start", int'(line_start), 1);
    step(0, 0, 1); step(0, 0, 1);
    hsl = 0; lsc = 0;
    for (int k = 0; k < 2 * HT; k++) begin
      step(0, 1, 1); step(0, 0, 1);
      lsc += int'(line_start);
      hsl += hsync ? 0 : 1;
      step(0, 0, 1); step(0, 0, 1);
    end
    chk("p4_line_starts", lsc, 2);
    chk("p4_hsync_low", hsl, 2 * HS);

    // One full frame at one strobe per clk.
    step(1, 0, 0); step(0, 1, 1);
    dec = 0; vsl = 0; fsc = 0; first = 1; fpx = -1; fpy = -1; lpx = -1; lpy = -1;
    for (int i = 0; i < FT; i++) begin
      step(0, 1, 1);
      fsc += int'(frame_start);
      vsl += vsync ? 0 : 1;
      if (display_enable) begin
        dec++;
        if (first) begin fpx = int'(pixel_x); fpy = int'(pixel_y); first = 0; end
        lpx = int'(pixel_x); lpy = int'(pixel_y);
      end
    end
    chk("frame_de_count", dec, HD * VD);
    chk("frame_vsync_low", vsl, VS * HT);
    chk("frame_first_px", fpx, 0);
    chk("frame_first_py", fpy, 0);
    chk("frame_last_px", lpx, HD - 1);
    chk("frame_last_py", lpy, VD - 1);
    chk("frame_fs_count", fsc, 1);
    step(0, 0, 1);
    chk("frame_wrap_fs", int'(frame_start), 1);

    // Drop run at line 3: the frame completes, then idle.
    for (int g = 0; g < FT && m_pos != 3 * HT; g++) step(0, 1, 1);
    cnt = 0; fsc = 0;
    while (busy && cnt < 2 * FT) begin
      step(0, 1, 0);
      cnt++;
      fsc += int'(frame_start);
    end
    chk("drain_strobes", cnt, FT - 3 * HT + 1);
    chk("drain_fs_count", fsc, 0);
    fsc = 0; aux = 0;
    for (int k = 0; k < HT; k++) begin
      step(0, 1, 0);
      fsc += int'(frame_start);
      aux += (busy || !hsync || !vsync) ? 1 : 0;
    end
    chk("idle_fs_count", fsc, 0);
    chk("idle_not_quiet", aux, 0);

    // Drop run on lines 2-3, re-raise at line 4: frame period unchanged.
    step(0, 1, 1); step(0, 1, 1);
    chk("rerun_first_fs", int'(frame_start), 1);
    cnt = 0;
    do begin
      rr = !(m_pos >= 2 * HT && m_pos < 4 * HT);
      step(0, 1, rr);
      cnt++;
    end while (!frame_start && cnt < 2 * FT);
    chk("rerun_period", cnt, FT);

    // Reset at h=7, v=5 for one clk.
    for (int g = 0; g < FT && m_pos != 5 * HT + 7; g++) step(0, 1, 1);
    step(1, 0, 1);
    chk("reset_idle_outputs", int'(act()), int'(pk(1, 1, 0, 0, 0, 0, 10'd0, 10'd0)));
    step(0, 0, 1);
    chk("reset_hold_idle", int'(busy), 0);
    step(0, 1, 1); step(0, 0, 1);
    chk("restart_fs", int'(frame_start), 1);
    chk("restart_hsync", int'(hsync), 0);

    // Random strobes, run toggles and rare resets.
    rr = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) rr = !rr;
      step($urandom_range(0, 799) == 0, 1'($urandom_range(0, 1)), rr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_scan_controller.md
VGA_SCAN_CONTROLLER -- requirements
Module: vga_scan_controller

Interface
REQ-001 SHALL have parameter H_SYNC_TIME, default 96, hsync low width in pixel strobes.
REQ-002 SHALL have parameter H_BACK_PROCH, default 48, horizontal back porch in strobes.
REQ-003 SHALL have parameter H_DISPLAY_TIME, default 640, active pixels per line.
REQ-004 SHALL have parameter H_FRONT_PROCH, default 16, horizontal front porch in strobes.
REQ-005 SHALL have parameter V_SYNC_TIME, default 2, vsync low width in lines.
REQ-006 SHALL have parameters V_BACK_PROCH (default 33), V_DISPLAY_TIME (default 480) and V_FRONT_PROCH (default 10), in lines.
REQ-007 SHALL have port clk, input, 1, system clock; the block uses one clock only.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port clk_25Mhz, input, 1, pixel strobe, one clk cycle wide; qualifies all advances.
REQ-010 SHALL have port run, input, 1, level request to scan frames.
REQ-011 SHALL have ports hsync and vsync, output, 1 each, active-low sync.
REQ-012 SHALL have port display_enable, output, 1, high in the active area.
REQ-013 SHALL have ports pixel_x and pixel_y, output, 10 each, active-area coordinates.
REQ-014 SHALL have ports line_start and frame_start, output, 1 each, single-clk pulses.
REQ-015 SHALL have port busy, output, 1, high while not IDLE.

Function
REQ-016 SHALL keep h_cnt 0..HT-1 (HT = H total = 800) and v_cnt 0..VT-1 (VT = 525), advancing only on clk cycles with clk_25Mhz=1.
REQ-017 SHALL order phases per axis SYNC, BACK, DISPLAY, FRONT; default h: 0-95, 96-143, 144-783, 784-799; v: 0-1, 2-34, 35-514, 515-524.
REQ-018 SHALL wrap h_cnt from HT-1 to 0 and increment v_cnt on that wrap; v_cnt wraps VT-1 to 0.
REQ-019 SHALL register every output from the counters in the clk cycle after the strobe that produced that counter value (latency one clk).
REQ-020 SHALL drive hsync=0 in h SYNC and vsync=0 in v SYNC, else 1.
REQ-021 SHALL drive display_enable=1 only when both axes are in DISPLAY, with pixel_x=h_cnt-144 and pixel_y=v_cnt-35; both 0 otherwise.
REQ-022 SHALL pulse line_start for one clk when h_cnt becomes 0, and frame_start for one clk when h_cnt and v_cnt both become 0.
REQ-023 SHALL implement FSM IDLE, RUN, DRAIN.
REQ-024 IDLE->RUN on the first strobe with run=1: counters load 0,0 and frame_start and line_start pulse.
REQ-025 RUN->DRAIN on any strobe with run=0; DRAIN->RUN on a strobe with run=1, with no counter disturbance.
REQ-026 DRAIN->IDLE on the strobe that wraps v_cnt to 0, so only complete frames are emitted; no frame_start pulses on that strobe.
REQ-027 In IDLE SHALL hold hsync=1, vsync=1, display_enable=0, pixel_x=0, pixel_y=0, busy=0, and counters at 0.
REQ-028 Strobes are ignored when reset=1; without a strobe all state holds.

Reset
REQ-029 reset=1 at any clk edge, including mid-frame, SHALL force IDLE, counters 0, and all outputs to IDLE values on the next cycle.
REQ-030 After reset release SHALL stay IDLE until a strobe with run=1.

Configuration
REQ-031 With VGA_FRAME_COUNT_EN defined, SHALL add output frame_count (16 bits), reset 0, incremented with each frame_start pulse, wrapping 65535->0.
REQ-032 Without VGA_FRAME_COUNT_EN, port frame_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Reset, run=1, strobe every 4th clk -> frame_start after first strobe; hsync low for 96 strobes, high for 704; line period 800 strobes.
REQ-034 Full frame -> vsync low for lines 0-1; display_enable high for exactly 640x480 strobes; first active pixel (0,0) at h=144,v=35; last active pixel (639,479).
REQ-035 Drop run at line 100 -> busy stays 1 through line 524, then IDLE with hsync=vsync=1 and no further frame_start.
REQ-036 Drop run and re-raise it at line 200 -> counters continue uninterrupted and the next frame_start occurs at the normal wrap.
REQ-037 Assert reset at h=300,v=50 for 1 clk -> next cycle all outputs at IDLE values; with run=1, restart at 0,0.
REQ-038 With VGA_FRAME_COUNT_EN, preload or run 65536 frames -> frame_count wraps to 0; without the macro, the port is absent at elaboration.
